// File: rtl/pcm_frame_tx.sv
// Serial PCM frame transmitter: latches a mono sample on new_frame and shifts it out
// twice (left and right slots) MSB-first on sdata, paced by bit_tick, with sync on bit 0.
module pcm_frame_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_BITS    = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bit_tick,
    input  logic                    new_frame,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    mute,
    input  logic                    clear_overrun,
    output logic                    sdata,
    output logic                    sync,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_SHIFT
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [FRAME_BITS-1:0]   r_shreg, w_shreg_nxt;
    logic [CNT_W-1:0]        r_cnt,   w_cnt_nxt;
    logic                    r_sdata, w_sdata_nxt;
    logic                    r_sync,  w_sync_nxt;
    logic                    r_done,  w_done_nxt;
    logic                    r_ovr,   w_ovr_nxt;

    logic [SLOT_BITS-1:0]    w_slot;
    logic [FRAME_BITS-1:0]   w_load;
    logic                    w_complete;
    logic                    w_accept;

    // Sample sits at the top of the slot; the low pad bits stay zero.
    always_comb begin
        w_slot = '0;
        w_slot[SLOT_BITS-1 -: SAMPLE_WIDTH] = mute ? '0 : sample_in;
    end

    assign w_load     = {w_slot, w_slot};
    assign w_complete = (r_state == S_SHIFT) && bit_tick && (r_cnt == LAST_CNT);
    assign w_accept   = new_frame && ((r_state == S_IDLE) || w_complete);

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_sdata_nxt = r_sdata;
        w_sync_nxt  = r_sync;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (new_frame) begin
                    w_shreg_nxt = w_load;
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bit_tick) begin
                    w_sdata_nxt = r_shreg[FRAME_BITS-1];
                    w_sync_nxt  = 1'b1;
                    w_shreg_nxt = {r_shreg[FRAME_BITS-2:0], 1'b0};
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_tick) begin
                    if (r_cnt == LAST_CNT) begin
                        // End of the last bit period; a request here starts the next frame.
                        w_sdata_nxt = 1'b0;
                        w_sync_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        if (new_frame) begin
                            w_shreg_nxt = w_load;
                            w_state_nxt = S_ARMED;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_sdata_nxt = r_shreg[FRAME_BITS-1];
                        w_sync_nxt  = 1'b0;
                        w_shreg_nxt = {r_shreg[FRAME_BITS-2:0], 1'b0};
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Set dominates clear.
    assign w_ovr_nxt = (r_ovr && !clear_overrun) || (new_frame && !w_accept);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_sdata <= 1'b0;
            r_sync  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sdata <= w_sdata_nxt;
            r_sync  <= w_sync_nxt;
            r_done  <= w_done_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    assign sdata      = r_sdata;
    assign sync       = r_sync;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_done;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_pcm_frame_tx.sv
// Randomized bench for pcm_frame_tx: frames are captured tick by tick and compared
// with a per-bit model of the slot layout.
module tb_pcm_frame_tx;

    logic        clk;
    logic        reset;
    logic        bit_tick;
    logic        new_frame;
    logic [15:0] sample_in;
    logic        mute;
    logic        clear_overrun;
    logic        sdata;
    logic        sync;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    pcm_frame_tx #(.SAMPLE_WIDTH(16), .SLOT_BITS(20)) dut (
        .clk           (clk),
        .reset         (reset),
        .bit_tick      (bit_tick),
        .new_frame     (new_frame),
        .sample_in     (sample_in),
        .mute          (mute),
        .clear_overrun (clear_overrun),
        .sdata         (sdata),
        .sync          (sync),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit i of the frame: slot position i%20, sample bits first, then zero pad.
    function automatic logic [39:0] exp_frame(input logic [15:0] smp, input logic m);
        logic [39:0] f;
        f = '0;
        for (int i = 0; i < 40; i++) begin
            int p;
            p = i % 20;
            if (!m && p < 16) f[39-i] = smp[15-p];
        end
        return f;
    endfunction

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic start_frame(input logic [15:0] smp, input logic m, input logic tk);
        sample_in = smp; mute = m; new_frame = 1'b1; bit_tick = tk;
        cyc();
        new_frame = 1'b0; bit_tick = 1'b0;
    endtask

    // Issues n ticks with random idle gaps; new_frame rides along with tick nf_at.
    task automatic capture(input int n, input int nf_at, output logic [39:0] bits,
                           output logic [40:0] syn, output logic [40:0] dn,
                           output logic [40:0] ovr, output logic [40:0] bsy);
        bits = '0; syn = '0; dn = '0; ovr = '0; bsy = '0;
        for (int k = 1; k <= n; k++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            repeat (gap) cyc();
            bit_tick = 1'b1; new_frame = (k == nf_at);
            cyc();
            bit_tick = 1'b0; new_frame = 1'b0;
            if (k <= 40) bits[40-k] = sdata;
            syn[k-1] = sync; dn[k-1] = frame_done; ovr[k-1] = overrun; bsy[k-1] = busy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; bit_tick = 0; new_frame = 0; sample_in = 16'hFFFF; mute = 0; clear_overrun = 0;
        #2;
        n_vec++;
        if ({sdata, sync, busy, frame_done, overrun} !== 5'b0) begin
            n_err++; $display("FAIL reset_state got=%b want=00000", {sdata, sync, busy, frame_done, overrun});
        end
        cyc(); cyc();
        reset = 1'b1;
        for (int c = 0; c < 100; c++) begin
            bit_tick = (c % 4 == 0);
            cyc();
            n_vec++;
            if ({sdata, sync, busy, frame_done, overrun} !== 5'b0) begin
                n_err++; $display("FAIL idle_ticks c=%0d got=%b want=00000", c, {sdata, sync, busy, frame_done, overrun});
            end
        end
        bit_tick = 0;
    endtask

    task automatic check_full(input string nm, input logic [15:0] smp, input logic m, input logic tk);
        logic [39:0] bits; logic [40:0] syn, dn, ovr, bsy;
        start_frame(smp, m, tk);
        sample_in = 16'($urandom); mute = 1'($urandom);
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_armed got=%b want=1", nm, busy); end
        capture(41, 0, bits, syn, dn, ovr, bsy);
        n_vec++;
        if (bits !== exp_frame(smp, m)) begin
            n_err++; $display("FAIL %s bits got=%h want=%h", nm, bits, exp_frame(smp, m));
        end
        n_vec++;
        if (syn !== 41'h1 || dn !== (41'h1 << 40)) begin
            n_err++; $display("FAIL %s sync/done got=%h/%h want=%h/%h", nm, syn, dn, 41'h1, 41'h1 << 40);
        end
        n_vec++;
        if (bsy !== {1'b0, {40{1'b1}}} || sdata !== 1'b0) begin
            n_err++; $display("FAIL %s busy/sdata_end got=%h/%b want=%h/0", nm, bsy, sdata, {1'b0, {40{1'b1}}});
        end
        cyc();
        n_vec++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_err++; $display("FAIL %s after done/busy/ovr got=%b%b%b want=000", nm, frame_done, busy, overrun);
        end
    endtask

    task automatic test_frame();
        check_full("a5c3", 16'hA5C3, 1'b0, 1'b0);
        check_full("tick_on_load", 16'h5A3C, 1'b0, 1'b1);
    endtask

    task automatic test_mute();
        check_full("mute", 16'h7FFF, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++)
            check_full("random", 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic test_back_to_back();
        logic [39:0] bits; logic [40:0] syn, dn, ovr, bsy;
        logic [15:0] a;
        a = 16'($urandom);
        start_frame(a, 1'b0, 1'b0);
        sample_in = 16'h8001; mute = 1'b0;
        capture(41, 41, bits, syn, dn, ovr, bsy);
        n_vec++;
        if (bits !== exp_frame(a, 1'b0)) begin n_err++; $display("FAIL b2b first_bits got=%h want=%h", bits, exp_frame(a, 1'b0)); end
        n_vec++;
        if (dn !== (41'h1 << 40) || ovr !== '0 || bsy !== {41{1'b1}}) begin
            n_err++; $display("FAIL b2b done/ovr/busy got=%h/%h/%h want=%h/0/%h", dn, ovr, bsy, 41'h1 << 40, {41{1'b1}});
        end
        sample_in = 16'h0000;
        capture(41, 0, bits, syn, dn, ovr, bsy);
        n_vec++;
        if (bits !== exp_frame(16'h8001, 1'b0) || syn !== 41'h1) begin
            n_err++; $display("FAIL b2b second got=%h sync=%h want=%h sync=1", bits, syn, exp_frame(16'h8001, 1'b0));
        end
        n_vec++;
        if (dn !== (41'h1 << 40) || overrun !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL b2b second_end done=%h ovr=%b busy=%b", dn, overrun, busy);
        end
    endtask

    task automatic test_overrun();
        logic [39:0] bits; logic [40:0] syn, dn, ovr, bsy;
        logic [15:0] a;
        a = 16'($urandom);
        start_frame(a, 1'b0, 1'b0);
        sample_in = ~a;
        capture(41, 11, bits, syn, dn, ovr, bsy);
        n_vec++;
        if (bits !== exp_frame(a, 1'b0) || dn !== (41'h1 << 40)) begin
            n_err++; $display("FAIL ovr frame_unchanged got=%h done=%h want=%h", bits, dn, exp_frame(a, 1'b0));
        end
        n_vec++;
        if (ovr !== {{31{1'b1}}, {10{1'b0}}}) begin
            n_err++; $display("FAIL ovr flag_mask got=%h want=%h", ovr, {{31{1'b1}}, {10{1'b0}}});
        end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL ovr busy_end got=%b want=0", busy); end
        clear_overrun = 1'b1; cyc(); clear_overrun = 1'b0;
        n_vec++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr clear got=%b want=0", overrun); end
        start_frame(16'h1111, 1'b0, 1'b0);
        new_frame = 1'b1; clear_overrun = 1'b1; sample_in = 16'hEEEE;
        cyc();
        new_frame = 1'b0; clear_overrun = 1'b0;
        n_vec++;
        if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr set_wins got=%b want=1", overrun); end
        capture(41, 0, bits, syn, dn, ovr, bsy);
        n_vec++;
        if (bits !== exp_frame(16'h1111, 1'b0)) begin
            n_err++; $display("FAIL ovr second_frame got=%h want=%h", bits, exp_frame(16'h1111, 1'b0));
        end
        clear_overrun = 1'b1; cyc(); clear_overrun = 1'b0;
        n_vec++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr clear2 got=%b want=0", overrun); end
    endtask

    task automatic test_reset_mid();
        logic [39:0] bits; logic [40:0] syn, dn, ovr, bsy;
        logic seen;
        start_frame(16'hFFFF, 1'b0, 1'b0);
        capture(25, 0, bits, syn, dn, ovr, bsy);
        n_vec++;
        if (sdata !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL rst_mid pre got sdata=%b busy=%b want=1/1", sdata, busy); end
        #3 reset = 1'b0;
        #1;
        n_vec++;
        if ({sdata, sync, busy, frame_done, overrun} !== 5'b0) begin
            n_err++; $display("FAIL rst_mid async got=%b want=00000", {sdata, sync, busy, frame_done, overrun});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            bit_tick = (c % 2 == 0);
            cyc();
            if (frame_done || busy || sdata || sync) seen = 1'b1;
        end
        bit_tick = 1'b0;
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid aborted got=activity want=idle"); end
        check_full("after_reset", 16'h1234, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_mute();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
